pixel_stream_out: RTL

Downstream of the shading stage: accepts one packed RGB888 pixel per `pixel_valid` pulse, buffers it in a small FIFO, and emits it as an AXI4-Stream video master with start-of-frame (`tuser`) and end-of-line (`tlast`) markers. The shading pipeline has no ready input, so this block absorbs the mismatch with a FIFO. It raises `stall` early enough for the ray-issue logic to stop launching new rays.

---
 rtl/pixel_stream_out_pkg.sv | 20 ++
 rtl/pixel_stream_out_fifo.sv | 68 ++++++
 rtl/pixel_stream_out.sv | 151 +++++++++++++++
 3 files changed

// File: rtl/pixel_stream_out_pkg.sv
// -----------------------------------------------------------------------------
// pixel_stream_out_pkg
// Shared video definitions for the pixel output path: the packed RGB888 pixel
// layout, the default pixel width and the default frame geometry.
// No ports (package).
// -----------------------------------------------------------------------------
package pixel_stream_out_pkg;

  localparam int PIXEL_W        = 24;
  localparam int DEFAULT_X_SIZE = 640;
  localparam int DEFAULT_Y_SIZE = 480;

  // Pixel layout as produced by the shading stage: {R, G, B}, R in the MSBs.
  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } rgb888_t;

endpackage

// File: rtl/pixel_stream_out_fifo.sv
// -----------------------------------------------------------------------------
// pixel_fifo
// Synchronous single-clock FIFO with a register-array store. The head entry
// is presented combinationally on rdata; push and pop are ignored when the
// FIFO is full or empty respectively.
//
// Ports:
//   clk    in   rising-edge clock
//   rst    in   synchronous active-low reset (empties the FIFO)
//   push   in   write wdata this cycle
//   pop    in   drop the head entry this cycle
//   wdata  in   WIDTH bits of write data
//   rdata  out  WIDTH bits, current head entry
//   count  out  number of stored entries (0..DEPTH)
//   full   out  count == DEPTH
//   empty  out  count == 0
// -----------------------------------------------------------------------------
module pixel_fifo #(
  parameter int WIDTH = 24,
  parameter int DEPTH = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic                       pop,
  input  logic [WIDTH-1:0]           wdata,
  output logic [WIDTH-1:0]           rdata,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       full,
  output logic                       empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q;
  logic [AW-1:0]    rd_ptr_q;
  logic [CW-1:0]    count_q;
  logic             do_push;
  logic             do_pop;

  assign full    = (count_q == CW'(DEPTH));
  assign empty   = (count_q == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign rdata   = mem_q[rd_ptr_q];
  assign count   = count_q;

  // DEPTH is a power of two, so the pointers wrap by plain overflow.
  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q <= count_q + CW'(do_push) - CW'(do_pop);
    end
  end

  // Storage is not reset; the pointers alone define which entries are live.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata;
  end

endmodule

// File: rtl/pixel_stream_out.sv
// -----------------------------------------------------------------------------
// pixel_stream_out
// Takes shaded pixels (no back-pressure upstream), buffers them in a FIFO and
// drives an AXI4-Stream video master with tuser on the first pixel of a frame
// and tlast on the last pixel of each line. stall warns the ray-issue logic
// early enough that in-flight pixels still fit.
//
// Ports:
//   clk            in   rising-edge clock
//   rst            in   synchronous active-low reset
//   pixel_in       in   PIXEL_W shaded pixel {R,G,B}
//   pixel_valid    in   pixel_in valid this cycle
//   stall          out  registered: FIFO occupancy >= FIFO_DEPTH-AF_MARGIN
//   m_axis_tdata   out  PIXEL_W output pixel
//   m_axis_tvalid  out  output valid
//   m_axis_tready  in   sink ready
//   m_axis_tuser   out  first pixel of frame
//   m_axis_tlast   out  last pixel of line
//   overflow       out  sticky, a pixel was dropped on a full FIFO
//   frame_done     out  one-cycle pulse after the last pixel of a frame
// -----------------------------------------------------------------------------
module pixel_stream_out
  import pixel_stream_out_pkg::*;
#(
  parameter int PIXEL_W    = pixel_stream_out_pkg::PIXEL_W,
  parameter int X_SIZE     = pixel_stream_out_pkg::DEFAULT_X_SIZE,
  parameter int Y_SIZE     = pixel_stream_out_pkg::DEFAULT_Y_SIZE,
  parameter int FIFO_DEPTH = 16,
  parameter int AF_MARGIN  = 6
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [PIXEL_W-1:0] pixel_in,
  input  logic               pixel_valid,
  output logic               stall,
  output logic [PIXEL_W-1:0] m_axis_tdata,
  output logic               m_axis_tvalid,
  input  logic               m_axis_tready,
  output logic               m_axis_tuser,
  output logic               m_axis_tlast,
  output logic               overflow,
  output logic               frame_done
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam int XW = (X_SIZE > 1) ? $clog2(X_SIZE) : 1;
  localparam int YW = (Y_SIZE > 1) ? $clog2(Y_SIZE) : 1;
  localparam logic [XW-1:0] X_LAST   = XW'(X_SIZE - 1);
  localparam logic [YW-1:0] Y_LAST   = YW'(Y_SIZE - 1);
  localparam logic [CW-1:0] AF_LEVEL = CW'(FIFO_DEPTH - AF_MARGIN);

  logic [PIXEL_W-1:0] fifo_rdata;
  logic [CW-1:0]      fifo_count;
  logic               fifo_full;
  logic               fifo_empty;
  logic               fifo_push;
  logic               fifo_pop;
  logic               handshake;
  logic [CW-1:0]      count_next;

  logic               tvalid_q, tvalid_d;
  logic [PIXEL_W-1:0] tdata_q, tdata_d;
  logic [XW-1:0]      x_q, x_d;
  logic [YW-1:0]      y_q, y_d;
  logic               stall_q, stall_d;
  logic               overflow_q, overflow_d;
  logic               frame_done_q, frame_done_d;

  pixel_fifo #(
    .WIDTH (PIXEL_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (fifo_push),
    .pop   (fifo_pop),
    .wdata (pixel_in),
    .rdata (fifo_rdata),
    .count (fifo_count),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign handshake  = tvalid_q & m_axis_tready;
  assign fifo_push  = pixel_valid & ~fifo_full;
  // The output register refills when empty or when its pixel leaves this cycle.
  assign fifo_pop   = ~fifo_empty & (~tvalid_q | m_axis_tready);
  assign count_next = fifo_count + CW'(fifo_push) - CW'(fifo_pop);

  always_comb begin
    tvalid_d     = tvalid_q;
    tdata_d      = tdata_q;
    x_d          = x_q;
    y_d          = y_q;
    frame_done_d = 1'b0;

    if (fifo_pop) begin
      tvalid_d = 1'b1;
      tdata_d  = fifo_rdata;
    end else if (handshake) begin
      tvalid_d = 1'b0;
    end

    if (handshake) begin
      if (x_q == X_LAST) begin
        x_d = '0;
        if (y_q == Y_LAST) begin
          y_d          = '0;
          frame_done_d = 1'b1;
        end else begin
          y_d = y_q + 1'b1;
        end
      end else begin
        x_d = x_q + 1'b1;
      end
    end

    // Fullness is the pre-edge state, so a pop in the same cycle does not save the pixel.
    overflow_d = overflow_q | (pixel_valid & fifo_full);
    stall_d    = (count_next >= AF_LEVEL);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      tvalid_q     <= 1'b0;
      tdata_q      <= '0;
      x_q          <= '0;
      y_q          <= '0;
      stall_q      <= 1'b0;
      overflow_q   <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      tvalid_q     <= tvalid_d;
      tdata_q      <= tdata_d;
      x_q          <= x_d;
      y_q          <= y_d;
      stall_q      <= stall_d;
      overflow_q   <= overflow_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign m_axis_tdata  = tdata_q;
  assign m_axis_tvalid = tvalid_q;
  assign m_axis_tuser  = tvalid_q & (x_q == '0) & (y_q == '0);
  assign m_axis_tlast  = tvalid_q & (x_q == X_LAST);
  assign stall         = stall_q;
  assign overflow      = overflow_q;
  assign frame_done    = frame_done_q;

endmodule
